// File: rtl/apb_cfg_master.sv
// APB initiator for the accelerator register port: single writes, reads and
// poll-reads (repeat a read until a masked compare matches or attempts run out).
module apb_cfg_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int POLL_LIMIT = 1024,
  parameter int POLL_GAP   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic                  cmd_poll,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, GAP, RESP} state_t;

  localparam logic [CNT_WIDTH-1:0] LIMIT_LAST = CNT_WIDTH'(POLL_LIMIT - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST   = CNT_WIDTH'((POLL_GAP > 0) ? (POLL_GAP - 1) : 0);

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  poll_q, poll_d;
  logic [DATA_WIDTH-1:0] expect_q, expect_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [CNT_WIDTH-1:0]  attempt_q, attempt_d;
  logic [CNT_WIDTH-1:0]  gap_q, gap_d;
  logic                  poll_match;

  assign poll_match = ((PRDATA & mask_q) == (expect_q & mask_q));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwdata_q      <= '0;
      poll_q        <= 1'b0;
      expect_q      <= '0;
      mask_q        <= '0;
      attempt_q     <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwdata_q      <= pwdata_d;
      poll_q        <= poll_d;
      expect_q      <= expect_d;
      mask_q        <= mask_d;
      attempt_q     <= attempt_d;
      gap_q         <= gap_d;
    end
  end

  // Next-state logic also computes the next value of every registered output.
  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwdata_d      = pwdata_q;
    poll_d        = poll_q;
    expect_d      = expect_q;
    mask_d        = mask_q;
    attempt_d     = attempt_q;
    gap_d         = gap_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          paddr_d     = cmd_addr;
          pwrite_d    = cmd_write;
          pwdata_d    = cmd_write ? cmd_wdata : '0;
          poll_d      = cmd_poll && !cmd_write;
          expect_d    = cmd_wdata;
          mask_d      = cmd_mask;
          attempt_d   = '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pwdata_d  = '0;
          if (pwrite_q) begin
            state_d       = RESP;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b0;
          end else if (!poll_q || poll_match) begin
            state_d       = RESP;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = PRDATA;
            rsp_timeout_d = 1'b0;
          end else if (attempt_q == LIMIT_LAST) begin
            state_d       = RESP;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = PRDATA;
            rsp_timeout_d = 1'b1;
          end else begin
            attempt_d = attempt_q + CNT_WIDTH'(1);
            gap_d     = '0;
            // With no gap configured the retry goes straight back onto the bus.
            if (POLL_GAP == 0) begin
              state_d = SETUP;
              psel_d  = 1'b1;
            end else begin
              state_d = GAP;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = SETUP;
          psel_d  = 1'b1;
        end else begin
          gap_d = gap_q + CNT_WIDTH'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Bench for apb_cfg_master: directed commands against a behavioural APB slave,
// a per-command outcome model, and a per-cycle compare process.
module tb_apb_cfg_master;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int LIMIT = 4;
  localparam int GAPC  = 4;

  logic          PCLK, PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write, cmd_poll;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata, cmd_mask;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PWRITE, PSEL, PENABLE, PREADY;
  logic [DW-1:0] PWDATA, PRDATA;

  apb_cfg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLL_LIMIT(LIMIT),
                   .POLL_GAP(GAPC), .CNT_WIDTH(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_poll(cmd_poll), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_mask(cmd_mask), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    int            reads;
    logic [DW-1:0] rdata;
    logic          timeout;
  } exp_t;

  int            tests = 0;
  int            fails = 0;
  int            cycle = 0;
  int            slave_waits = 0;
  logic [DW-1:0] rd_default = '0;
  logic [DW-1:0] rd_q[$];
  exp_t          exp_q[$];
  exp_t          cur;
  bit            busy = 0;
  bit            mon_en = 0;
  bit            prev_psel = 0;
  int            idle_run = 0;
  int            reads_seen = 0;
  int            last_reads = 0;

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial forever begin
    @(posedge PCLK);
    cycle++;
  end

  task automatic check_output(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic report_fail(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: event did not occur within its cycle budget", name);
  endtask

  // Outcome of one command derived from the slave's queued read data.
  function automatic exp_t model_cmd(input logic write, input logic poll, input logic [AW-1:0] addr,
                                     input logic [DW-1:0] wdata, input logic [DW-1:0] mask);
    exp_t e;
    logic [DW-1:0] d;
    e.addr = addr; e.write = write; e.wdata = wdata;
    e.reads = 0; e.rdata = '0; e.timeout = 1'b0;
    if (write) return e;
    for (int i = 0; i < LIMIT; i++) begin
      d = (i < rd_q.size()) ? rd_q[i] : rd_default;
      e.reads = i + 1;
      e.rdata = d;
      if (!poll || ((d & mask) == (wdata & mask))) return e;
    end
    e.timeout = 1'b1;
    return e;
  endfunction

  // APB slave: answers after slave_waits ACCESS cycles, read data from rd_q.
  initial begin
    int acc;
    acc = 0;
    PREADY = 1'b0;
    PRDATA = '0;
    forever begin
      @(posedge PCLK);
      #1;
      if (PSEL && PENABLE) begin
        if (acc == slave_waits) begin
          PREADY = 1'b1;
          if (!PWRITE) begin
            if (rd_q.size() > 0) PRDATA = rd_q.pop_front();
            else PRDATA = rd_default;
          end
        end else begin
          PREADY = 1'b0;
        end
        acc++;
      end else begin
        acc = 0;
        PREADY = 1'b0;
        PRDATA = '0;
      end
    end
  end

  // Compare process: at each falling edge, check outputs then note what the next edge will do.
  initial forever begin
    @(negedge PCLK);
    if (mon_en && PRESETn) begin
      if (PENABLE) check_output("penable_without_psel", PSEL, 1'b1);
      if (PSEL && busy) begin
        check_output("paddr", PADDR, cur.addr);
        check_output("pwrite", PWRITE, cur.write);
        check_output("pwdata", PWDATA, cur.write ? cur.wdata : '0);
      end else if (!busy) begin
        check_output("psel_without_cmd", PSEL, 1'b0);
        check_output("rsp_without_cmd", rsp_valid, 1'b0);
      end
      if (!(PSEL && PWRITE)) check_output("pwdata_outside_write", PWDATA, '0);
      if (busy) check_output("cmd_ready_busy", cmd_ready, 1'b0);
      if (rsp_valid && busy) begin
        check_output("rsp_rdata", rsp_rdata, cur.rdata);
        check_output("rsp_timeout", rsp_timeout, cur.timeout);
        check_output("read_count", reads_seen, cur.reads);
        check_output("psel_during_resp", PSEL, 1'b0);
      end
      if (PSEL && !prev_psel && busy && reads_seen > 0)
        check_output("poll_gap_len", idle_run, GAPC);
      idle_run  = PSEL ? 0 : idle_run + 1;
      prev_psel = PSEL;
      if (PSEL && PENABLE && PREADY && !PWRITE) reads_seen++;
      if (rsp_valid && rsp_ready) begin
        busy = 0;
        last_reads = reads_seen;
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          report_fail("unexpected_accept");
        end else begin
          cur = exp_q.pop_front();
          busy = 1;
          reads_seen = 0;
          idle_run = 0;
        end
      end
    end else begin
      prev_psel = 0;
      idle_run = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic drive_cmd(input logic write, input logic poll, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] mask);
    exp_q.push_back(model_cmd(write, poll, addr, wdata, mask));
    cmd_write = write;
    cmd_poll  = poll;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_mask  = mask;
    cmd_valid = 1'b1;
  endtask

  // Drive a command and return just after the edge that accepts it.
  task automatic apply_stimulus(input logic write, input logic poll, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [DW-1:0] mask,
                                output int accept_cycle);
    bit ok;
    ok = 0;
    accept_cycle = -1;
    drive_cmd(write, poll, addr, wdata, mask);
    for (int i = 0; i < 50 && !ok; i++) begin
      if (cmd_ready) ok = 1;
      step(1);
    end
    cmd_valid = 1'b0;
    if (ok) accept_cycle = cycle;
    else report_fail("cmd_accept");
  endtask

  task automatic wait_response(output int acc, output logic [DW-1:0] rdata, output logic tmo);
    bit ok;
    ok = 0;
    acc = 0;
    rdata = 'x;
    tmo = 1'bx;
    for (int i = 0; i < 200 && !ok; i++) begin
      step(1);
      if (PSEL && PENABLE) acc++;
      if (rsp_valid) begin
        ok = 1;
        rdata = rsp_rdata;
        tmo = rsp_timeout;
      end
    end
    if (!ok) report_fail("rsp_wait");
    step(1);
  endtask

  initial begin
    int            acc, t0, t1;
    logic [DW-1:0] rd;
    logic          tmo;
    logic          tw[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic          tp[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [AW-1:0] ta[4]  = '{8'h10, 8'h0C, 8'h20, 8'h04};
    logic [DW-1:0] twd[4] = '{32'hA5A55A5A, 32'h0000CAFE, 32'h0, 32'h30};
    logic [DW-1:0] tm[4]  = '{32'h0, 32'hFFFF, 32'h0, 32'hF0};
    logic [DW-1:0] trd[4] = '{32'h0, 32'h0, 32'h12345678, 32'h3F};
    int            twt[4] = '{0, 0, 1, 0};
    int            tacc[4];

    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_poll = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0; rsp_ready = 1'b1;

    #2;
    check_output("reset_cmd_ready", cmd_ready, 1'b0);
    check_output("reset_psel", PSEL, 1'b0);
    check_output("reset_penable", PENABLE, 1'b0);
    check_output("reset_rsp_valid", rsp_valid, 1'b0);
    check_output("reset_paddr", PADDR, '0);
    check_output("reset_pwdata", PWDATA, '0);
    check_output("reset_rsp_rdata", rsp_rdata, '0);
    #21;
    PRESETn = 1'b1;
    #1;
    check_output("ready_before_first_edge", cmd_ready, 1'b0);
    step(1);
    check_output("ready_after_first_edge", cmd_ready, 1'b1);
    mon_en = 1;

    // Write with literal latency checks.
    apply_stimulus(1'b1, 1'b0, 8'h00, 32'h1, 32'h0, t0);
    check_output("w_setup_psel", PSEL, 1'b1);
    check_output("w_setup_penable", PENABLE, 1'b0);
    check_output("w_setup_pwrite", PWRITE, 1'b1);
    check_output("w_setup_pwdata", PWDATA, 32'h1);
    step(1);
    check_output("w_access_penable", PENABLE, 1'b1);
    check_output("w_access_rsp_valid", rsp_valid, 1'b0);
    step(1);
    check_output("w_rsp_valid", rsp_valid, 1'b1);
    check_output("w_rsp_rdata", rsp_rdata, 32'h0);
    check_output("w_rsp_timeout", rsp_timeout, 1'b0);
    check_output("w_rsp_psel", PSEL, 1'b0);
    step(1);
    check_output("w_done_rsp_valid", rsp_valid, 1'b0);
    check_output("w_done_cmd_ready", cmd_ready, 1'b1);

    // Read with three wait states.
    slave_waits = 3;
    rd_q.push_back(32'hDEADBEEF);
    apply_stimulus(1'b0, 1'b0, 8'h08, 32'h0, 32'h0, t0);
    wait_response(acc, rd, tmo);
    check_output("rd_access_cycles", acc, 4);
    check_output("rd_rdata", rd, 32'hDEADBEEF);
    slave_waits = 0;

    // Poll that matches on the third read.
    rd_q.push_back(32'h0); rd_q.push_back(32'h0); rd_q.push_back(32'h3);
    apply_stimulus(1'b0, 1'b1, 8'h04, 32'h1, 32'h1, t0);
    wait_response(acc, rd, tmo);
    check_output("poll_reads", last_reads, 3);
    check_output("poll_rdata", rd, 32'h3);
    check_output("poll_timeout", tmo, 1'b0);

    // Poll that never matches.
    apply_stimulus(1'b0, 1'b1, 8'h04, 32'h1, 32'hFFFFFFFF, t0);
    wait_response(acc, rd, tmo);
    check_output("poll_to_reads", last_reads, LIMIT);
    check_output("poll_to_rdata", rd, 32'h0);
    check_output("poll_to_timeout", tmo, 1'b1);

    // Mixed vectors, back to back.
    for (int i = 0; i < 4; i++) begin
      slave_waits = twt[i];
      if (!tw[i]) rd_q.push_back(trd[i]);
      apply_stimulus(tw[i], tp[i], ta[i], twd[i], tm[i], tacc[i]);
      wait_response(acc, rd, tmo);
    end
    slave_waits = 0;
    check_output("cmd_spacing", tacc[1] - tacc[0], 4);
    check_output("write_poll_ignored_reads", 32'(tacc[1] > 0 ? 0 : 1), 32'h0);
    check_output("poll_first_match_rdata", rd, 32'h3F);
    check_output("poll_first_match_reads", last_reads, 1);

    // Response back-pressure with the next command already waiting.
    rsp_ready = 1'b0;
    rd_q.push_back(32'h55AA00FF);
    apply_stimulus(1'b0, 1'b0, 8'h14, 32'h0, 32'h0, t0);
    drive_cmd(1'b1, 1'b0, 8'h18, 32'h77, 32'h0);
    t1 = 0;
    for (int i = 0; i < 20 && !rsp_valid; i++) step(1);
    if (!rsp_valid) report_fail("bp_rsp_wait");
    for (int k = 0; k < 5; k++) begin
      check_output("bp_rsp_valid", rsp_valid, 1'b1);
      check_output("bp_rsp_rdata", rsp_rdata, 32'h55AA00FF);
      check_output("bp_cmd_ready", cmd_ready, 1'b0);
      check_output("bp_psel", PSEL, 1'b0);
      step(1);
    end
    rsp_ready = 1'b1;
    step(1);
    check_output("bp_consumed_rsp_valid", rsp_valid, 1'b0);
    check_output("bp_consumed_cmd_ready", cmd_ready, 1'b1);
    check_output("bp_not_yet_accepted", PSEL, 1'b0);
    step(1);
    check_output("bp_next_psel", PSEL, 1'b1);
    check_output("bp_next_paddr", PADDR, 8'h18);
    cmd_valid = 1'b0;
    wait_response(acc, rd, tmo);
    check_output("bp_next_rdata", rd, 32'h0);

    // Reset in the middle of an ACCESS phase.
    slave_waits = 10;
    apply_stimulus(1'b0, 1'b0, 8'h2C, 32'h0, 32'h0, t0);
    step(1);
    check_output("rst_in_access_penable", PENABLE, 1'b1);
    mon_en = 0;
    #3;
    PRESETn = 1'b0;
    #1;
    check_output("rst_async_psel", PSEL, 1'b0);
    check_output("rst_async_penable", PENABLE, 1'b0);
    check_output("rst_async_rsp_valid", rsp_valid, 1'b0);
    check_output("rst_async_cmd_ready", cmd_ready, 1'b0);
    #8;
    PRESETn = 1'b1;
    #1;
    check_output("rst_release_cmd_ready", cmd_ready, 1'b0);
    step(1);
    check_output("rst_first_edge_cmd_ready", cmd_ready, 1'b1);
    exp_q.delete();
    busy = 0;
    slave_waits = 0;
    mon_en = 1;
    apply_stimulus(1'b1, 1'b0, 8'h30, 32'hBEEF0001, 32'h0, t0);
    check_output("rst_after_pwdata", PWDATA, 32'hBEEF0001);
    wait_response(acc, rd, tmo);
    check_output("rst_after_rdata", rd, 32'h0);
    check_output("rst_after_timeout", tmo, 1'b0);

    step(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_cfg_master.md
Name: apb_cfg_master

Overview:
- APB initiator that drives the accelerator's register (cfg) slave port: PADDR/PWRITE/PSEL/PENABLE/PWDATA out, PRDATA/PREADY in.
- A host-side sequencer or testbench issues single register commands over a valid/ready command port. Results return on a valid/ready response port.
- Supports plain writes, plain reads, and a poll-read mode. Poll-read repeats a register read until a masked compare matches, or an attempt limit expires. Typical use is waiting for done_tpu.

Parameters:
- ADDR_WIDTH, 8, APB address width (matches register address width).
- DATA_WIDTH, 32, APB data width (matches register data width).
- POLL_LIMIT, 1024, maximum read attempts per poll command; must be >=1.
- POLL_GAP, 4, idle cycles between consecutive poll reads; 0 allowed.
- CNT_WIDTH, 16, width of the attempt and gap counters; must hold POLL_LIMIT and POLL_GAP.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_poll  in  1  poll-read mode; ignored when cmd_write=1.
- cmd_addr  in  ADDR_WIDTH  register address.
- cmd_wdata  in  DATA_WIDTH  write data, or poll expected value.
- cmd_mask  in  DATA_WIDTH  poll compare mask.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data (last PRDATA sampled); 0 for writes.
- rsp_timeout  out  1  poll ended without a match.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Reset (PRESETn=0, asynchronous):
  - State is IDLE; all outputs are 0, including cmd_ready.
  - cmd_ready rises on the first PCLK edge after PRESETn goes high.
  - All outputs are registered.
- States: IDLE, SETUP, ACCESS, GAP, RESP.
- IDLE:
  - cmd_ready=1 and PSEL=PENABLE=0.
  - When cmd_valid&cmd_ready at an edge: capture the command, clear the attempt counter, set cmd_ready=0, go to SETUP.
  - PWRITE is forced to 0 for reads and polls; PWDATA=cmd_wdata for writes, 0 otherwise.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA valid. Go to ACCESS after one cycle.
- ACCESS:
  - PSEL=1, PENABLE=1; all APB outputs held stable.
  - Stay in ACCESS while PREADY=0; there is no wait limit.
  - On PREADY=1, the transfer completes: PSEL=PENABLE=0 next cycle, and the next state is chosen as follows.
- Transfer completion, by command type:
  - Write: rsp_rdata=0, rsp_timeout=0, go to RESP.
  - Plain read: rsp_rdata=PRDATA, rsp_timeout=0, go to RESP.
  - Poll, match ((PRDATA&cmd_mask)==(cmd_wdata&cmd_mask)): rsp_rdata=PRDATA, rsp_timeout=0, go to RESP.
  - Poll, no match, attempt count == POLL_LIMIT-1: rsp_rdata=PRDATA, rsp_timeout=1, go to RESP.
  - Poll, no match otherwise: increment the attempt counter, go to GAP (or directly to SETUP if POLL_GAP=0).
- GAP: PSEL=0 for exactly POLL_GAP cycles, then go to SETUP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_timeout held stable until rsp_ready=1 at an edge.
  - On that edge: rsp_valid=0, cmd_ready=1, go to IDLE.
  - No new command is accepted in the cycle where the response is consumed.
- Latency: accept at edge T gives SETUP at T+1, ACCESS at T+2, and with PREADY=1, rsp_valid at T+3.
  - Minimum spacing between accepted commands is 4 cycles with rsp_ready tied high.
- Poll with POLL_LIMIT=1 performs exactly one read.
- PADDR holds its last value while idle; PWDATA is 0 outside write transfers.
- Reset asserted mid-transfer aborts immediately: PSEL/PENABLE drop asynchronously and any pending response is lost.
- cmd_valid while cmd_ready=0 is ignored; the command stays on the port until accepted.

Test Plan:
- Write addr 0x00 data 0x00000001, PREADY=1:
  - SETUP at T+1 (PSEL=1, PENABLE=0, PWRITE=1, PWDATA=1); ACCESS at T+2; rsp_valid at T+3 with rsp_rdata=0, rsp_timeout=0.
- Read addr 0x08, PREADY=0 for 3 ACCESS cycles then 1 with PRDATA=0xDEADBEEF:
  - ACCESS lasts 4 cycles with PADDR=0x08 and PSEL/PENABLE stable; rsp_rdata=0xDEADBEEF.
- Poll addr 0x04, mask 0x1, expected 0x1, POLL_GAP=4; slave returns 0x0, 0x0, then 0x3:
  - Exactly 3 APB reads, each separated by 4 idle cycles; rsp_rdata=0x3, rsp_timeout=0.
- Poll with POLL_LIMIT=4, slave always returns 0:
  - Exactly 4 reads, then rsp_timeout=1 and rsp_rdata=0.
- rsp_ready held low for 5 cycles after rsp_valid, cmd_valid held high throughout:
  - Response stable, cmd_ready=0, no PSEL activity; next command accepted only after rsp_ready=1.
- PRESETn pulsed low during ACCESS:
  - PSEL, PENABLE, rsp_valid and cmd_ready go to 0 without a clock edge; cmd_ready=1 on the first edge after release; a new write then completes normally.
